uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (start/txin/txdone interface) among NREQ byte-producing requesters.
- Uses round-robin arbitration, one full frame per grant.
- Sequences the transmitter's start pulse, holds txin stable for the whole frame, waits for txdone, then enforces a guard gap so the transmitter can return to idle.
- A watchdog aborts a grant if txdone never arrives.

---
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
// One frame per grant, watchdog abort, and a guard gap between frames.
module uart_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int TIMEOUT    = 255,
    parameter int GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ack,
    output logic              uart_start,
    output logic [7:0]        uart_txin,
    input  logic              uart_txdone,
    output logic              done,
    output logic [2:0]        done_id,
    output logic              err,
    output logic              busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, START, BUSY, GAP} state_t;

    state_t        state;
    logic [2:0]    rr_ptr;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;

    logic          hi_found;
    logic [2:0]    hi_sel;
    logic [2:0]    lo_sel;
    logic [2:0]    sel;
    logic [7:0]    sel_byte;

    // Prefer the lowest index above rr_ptr, else wrap to the lowest index.
    always_comb begin
        hi_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                lo_sel = 3'(k);
                if (3'(k) > rr_ptr) begin
                    hi_found = 1'b1;
                    hi_sel   = 3'(k);
                end
            end
        end
        sel = hi_found ? hi_sel : lo_sel;
    end

    always_comb begin
        sel_byte = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (sel == 3'(k)) begin
                sel_byte = req_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 3'(NREQ - 1);
            tcnt       <= '0;
            gcnt       <= '0;
            req_ack    <= '0;
            uart_start <= 1'b0;
            uart_txin  <= '0;
            done       <= 1'b0;
            done_id    <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        uart_txin <= sel_byte;
                        done_id   <= sel;
                        rr_ptr    <= sel;
                        req_ack   <= NREQ'(1) << sel;
                        busy      <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    req_ack    <= '0;
                    uart_start <= 1'b1;
                    state      <= START;
                end
                START: begin
                    uart_start <= 1'b0;
                    tcnt       <= '0;
                    state      <= BUSY;
                end
                BUSY: begin
                    tcnt <= tcnt + 1'b1;
                    // txdone has priority over a simultaneous watchdog hit
                    if (uart_txdone) begin
                        done  <= 1'b1;
                        gcnt  <= '0;
                        state <= GAP;
                    end else if (tcnt == TW'(TIMEOUT)) begin
                        err   <= 1'b1;
                        gcnt  <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (gcnt == GW'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus corner-case
// sequences for watchdog, coincidence, spurious txdone and reset.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int TO = 255;
    localparam int GC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0] req_ack;
    logic          uart_start;
    logic [7:0]    uart_txin;
    logic          uart_txdone;
    logic          done;
    logic [2:0]    done_id;
    logic          err;
    logic          busy;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(.NREQ(NR), .TIMEOUT(TO), .GAP_CYCLES(GC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
        .uart_start(uart_start), .uart_txin(uart_txin),
        .uart_txdone(uart_txdone),
        .done(done), .done_id(done_id), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_first;
        logic [3:0]  valid;
        logic [31:0] data;
        int          blen;
        logic [2:0]  id;
        logic [7:0]  byt;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        uart_txdone = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_ack(output int w);
        w = 0;
        do begin
            step();
            w++;
        end while (req_ack == '0 && w < 100);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 50) begin
            step();
            w++;
        end
        chk("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic serve(input logic [3:0] v, input logic [31:0] d,
                         input int blen, input logic [2:0] id,
                         input logic [7:0] byt, input bit chk_lat);
        int w;
        req_data  = d;
        req_valid = v;
        wait_ack(w);
        chk("ack_onehot", req_ack, 32'(4'b0001 << id));
        if (chk_lat) chk("ack_latency", w, 1);
        chk("txin_at_ack", uart_txin, byt);
        chk("id_at_ack", done_id, id);
        chk("busy_at_ack", busy, 1);
        req_valid = v & ~req_ack;
        step();
        chk("start_pulse", {req_ack, uart_start}, 5'b0000_1);
        step();
        chk("start_end", uart_start, 0);
        repeat (blen - 1) step();
        uart_txdone = 1'b1;
        step();
        uart_txdone = 1'b0;
        chk("done_pulse", {done, err, done_id}, {1'b1, 1'b0, id});
        chk("txin_held", uart_txin, byt);
        for (int j = 1; j < GC; j++) begin
            step();
            chk("gap_busy", {uart_start, done, busy}, 3'b001);
        end
        step();
        chk("busy_drop", busy, 0);
    endtask

    initial begin
        int k;
        int w;
        bit saw_done;

        vecs[0] = '{1'b1, 4'b0100, 32'h00A5_0000, 100, 3'd2, 8'hA5};
        vecs[1] = '{1'b1, 4'b1111, 32'h1312_1110,   3, 3'd0, 8'h10};
        vecs[2] = '{1'b0, 4'b1111, 32'h1312_1110,   5, 3'd1, 8'h11};
        vecs[3] = '{1'b0, 4'b1111, 32'h1312_1110,   7, 3'd2, 8'h12};
        vecs[4] = '{1'b0, 4'b1111, 32'h1312_1110,   2, 3'd3, 8'h13};
        vecs[5] = '{1'b0, 4'b1111, 32'h1312_1110,   4, 3'd0, 8'h10};
        vecs[6] = '{1'b0, 4'b1000, 32'h1312_1110,   3, 3'd3, 8'h13};
        vecs[7] = '{1'b0, 4'b1010, 32'h1312_1110,   2, 3'd1, 8'h11};
        vecs[8] = '{1'b0, 4'b1010, 32'h1312_1110,   6, 3'd3, 8'h13};

        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        uart_txdone = 1'b0;
        do_reset();
        chk("reset_outputs",
            {req_ack, uart_start, uart_txin, done, done_id, err, busy}, 0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst_first) do_reset();
            serve(vecs[i].valid, vecs[i].data, vecs[i].blen,
                  vecs[i].id, vecs[i].byt, 1'b1);
        end

        // Watchdog: BUSY spans counter values 0..TO, err follows.
        do_reset();
        req_data = 32'h1312_1110;
        req_valid = 4'b0001;
        wait_ack(w);
        chk("to_ack", req_ack, 4'b0001);
        req_valid = 4'b0010;
        step();
        chk("to_start", uart_start, 1);
        k = 0;
        saw_done = 1'b0;
        do begin
            step();
            k++;
            saw_done |= done;
        end while (!err && k < TO + 20);
        chk("timeout_latency", k, TO + 2);
        chk("timeout_no_done", {31'd0, saw_done}, 0);
        serve(4'b0010, 32'h1312_1110, 4, 3'd1, 8'h11, 1'b0);

        // txdone on the same cycle the counter reaches TO.
        do_reset();
        req_valid = 4'b0001;
        wait_ack(w);
        req_valid = '0;
        step();
        repeat (TO + 1) step();
        uart_txdone = 1'b1;
        step();
        uart_txdone = 1'b0;
        chk("coincide", {done, err}, 2'b10);
        wait_idle();

        // txdone while idle must be ignored.
        uart_txdone = 1'b1;
        step();
        uart_txdone = 1'b0;
        repeat (3) step();
        chk("spurious_txdone", {req_ack, uart_start, done, err, busy}, 0);

        // Reset during BUSY abandons the frame and restores rr_ptr.
        req_valid = 4'b0100;
        wait_ack(w);
        chk("mid_ack", req_ack, 4'b0100);
        req_valid = '0;
        repeat (7) step();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_reset_outputs",
            {req_ack, uart_start, uart_txin, done, done_id, err, busy}, 0);
        repeat (3) step();
        chk("mid_reset_quiet", {done, err, busy}, 0);
        serve(4'b1111, 32'h1312_1110, 3, 3'd0, 8'h10, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
